alu_operand_stage: RTL and testbench

//   Issue stage directly upstream of alu_16bit. Decodes a 16-bit instruction, reads two operands

---
 rtl/alu_pkg.sv | 59 +++++
 rtl/alu_operand_stage_regfile_2r1w.sv | 62 ++++++
 rtl/alu_operand_stage.sv | 189 ++++++++++++++++++
 tb/tb_alu_operand_stage.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU issue path: the ALU opcode encodings, the
//   bit positions of the 16-bit instruction fields, a packed view of a decoded
//   instruction and a helper that splits a raw instruction word into its fields.
//
//   Instruction layout:
//     [15:13] op   [12:10] rd   [9:7] ra   [6:4] rb   [3] use_imm   [2:0] imm3
// -----------------------------------------------------------------------------
package alu_pkg;

    // ALU opcodes understood by alu_16bit. The issue stage forwards whatever
    // opcode it is given, so these exist for readability at call sites.
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_SHL   = 3'b010;
    localparam logic [2:0] ALU_SHR   = 3'b011;
    localparam logic [2:0] ALU_SAR   = 3'b100;
    localparam logic [2:0] ALU_SHADD = 3'b101;
    localparam logic [2:0] ALU_OR    = 3'b110;
    localparam logic [2:0] ALU_NAND  = 3'b111;

    localparam int INSTR_W     = 16;
    localparam int IMM_W       = 3;

    // Instruction field positions
    localparam int OP_MSB      = 15;
    localparam int OP_LSB      = 13;
    localparam int RD_MSB      = 12;
    localparam int RD_LSB      = 10;
    localparam int RA_MSB      = 9;
    localparam int RA_LSB      = 7;
    localparam int RB_MSB      = 6;
    localparam int RB_LSB      = 4;
    localparam int USE_IMM_BIT = 3;
    localparam int IMM_MSB     = 2;
    localparam int IMM_LSB     = 0;

    typedef struct packed {
        logic [2:0]       op;
        logic [2:0]       rd;
        logic [2:0]       ra;
        logic [2:0]       rb;
        logic             use_imm;
        logic [IMM_W-1:0] imm3;
    } instr_t;

    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] instr);
        instr_t d;
        d.op      = instr[OP_MSB:OP_LSB];
        d.rd      = instr[RD_MSB:RD_LSB];
        d.ra      = instr[RA_MSB:RA_LSB];
        d.rb      = instr[RB_MSB:RB_LSB];
        d.use_imm = instr[USE_IMM_BIT];
        d.imm3    = instr[IMM_MSB:IMM_LSB];
        return d;
    endfunction

endpackage

// File: rtl/alu_operand_stage_regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
//   NREG x DATA_W architectural register file with two combinational read
//   ports and one synchronous write port. Register 0 is hardwired to zero:
//   writes to it are dropped and reads of it return zero.
//
//   Ports
//     clk        clock, write happens on posedge
//     srst_i     synchronous active-high reset, clears every register
//     we_i       write enable
//     waddr_i    write address
//     wdata_i    write data
//     raddr_a_i  read port A address   -> rdata_a_o
//     raddr_b_i  read port B address   -> rdata_b_o
// -----------------------------------------------------------------------------
module regfile_2r1w #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              srst_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    // Reads are asynchronous and reset clears the whole array, so this is a
    // plain register array rather than a block RAM.
    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   wr_sel;

    // One-hot write select; entry 0 can never be selected.
    assign wr_sel[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_wsel
            assign wr_sel[gi] = we_i && (waddr_i == REG_AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wr_sel[i]) begin
                    regs_q[i] <= wdata_i;
                end
            end
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//   Issue stage in front of alu_16bit. Decodes an instruction, reads its two
//   source operands from the register file and holds {op, a, b, rd} in an
//   output register for the ALU. Results come back through the writeback port.
//   A scoreboard of pending destination registers stalls issue on RAW and WAW
//   hazards. Outputs change on posedge clk so they are stable at the ALU's
//   negedge sample point.
//
//   Build option (macro OPERAND_FWD_EN):
//     defined   - a pending source being written back in the same cycle is not
//                 a hazard; its value is bypassed from wb_data.
//     undefined - that case stalls one cycle and the value is read from the
//                 register file after the write lands.
//
//   Ports
//     clk, rst                      clock, synchronous active-high reset
//     in_valid / in_ready / in_instr   instruction input handshake
//     out_valid / out_ready            issued-operation handshake
//     out_op, out_a, out_b, out_rd     issued operation
//     wb_en, wb_addr, wb_data          result writeback
//     busy                             scoreboard has a pending write
// -----------------------------------------------------------------------------
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int REG_AW = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_op,
    output logic [DATA_W-1:0]  out_a,
    output logic [DATA_W-1:0]  out_b,
    output logic [REG_AW-1:0]  out_rd,
    input  logic               wb_en,
    input  logic [REG_AW-1:0]  wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               busy
);

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    instr_t            dec;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic [REG_AW-1:0] rd;

    assign dec = decode_instr(in_instr);
    assign ra  = dec.ra;
    assign rb  = dec.rb;
    assign rd  = dec.rd;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic              rf_we;

    assign rf_we = wb_en && (wb_addr != '0);

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk       (clk),
        .srst_i    (rst),
        .we_i      (rf_we),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data),
        .raddr_a_i (ra),
        .rdata_a_o (rf_a),
        .raddr_b_i (rb),
        .rdata_b_o (rf_b)
    );

    // ------------------------------------------------------------------
    // Scoreboard state. Bit 0 is never set, so r0 is never pending.
    // ------------------------------------------------------------------
    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    // ------------------------------------------------------------------
    // Source blocking and operand selection
    // ------------------------------------------------------------------
    logic              ra_blocked;
    logic              rb_blocked;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b_reg;

`ifdef OPERAND_FWD_EN
    logic wb_hit_ra;
    logic wb_hit_rb;

    // A writeback landing on a source this cycle satisfies it: bypass the
    // write data instead of waiting for the register file to update.
    assign wb_hit_ra  = rf_we && (wb_addr == ra);
    assign wb_hit_rb  = rf_we && (wb_addr == rb);
    assign ra_blocked = pending_q[ra] && !wb_hit_ra;
    assign rb_blocked = pending_q[rb] && !wb_hit_rb;
    assign opnd_a     = wb_hit_ra ? wb_data : rf_a;
    assign opnd_b_reg = wb_hit_rb ? wb_data : rf_b;
`else
    // Without the bypass the write must land first; the bit clears at the
    // same edge, so the instruction issues one cycle later.
    assign ra_blocked = pending_q[ra];
    assign rb_blocked = pending_q[rb];
    assign opnd_a     = rf_a;
    assign opnd_b_reg = rf_b;
`endif

    logic [DATA_W-1:0] opnd_b;
    assign opnd_b = dec.use_imm ? {{(DATA_W-IMM_W){1'b0}}, dec.imm3} : opnd_b_reg;

    // ------------------------------------------------------------------
    // Hazard and handshake. rb only matters when the immediate is not used;
    // the rd check blocks a second in-flight write to the same register.
    // ------------------------------------------------------------------
    logic hazard;
    logic accept;
    logic out_valid_q;

    assign hazard   = in_valid && (ra_blocked || (!dec.use_imm && rb_blocked) || pending_q[rd]);
    assign in_ready = !rst && !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Scoreboard next state. Set wins over clear for the same index so an
    // instruction issued while its destination retires keeps it pending.
    // ------------------------------------------------------------------
    assign pending_d[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_sb
            logic set_hit;
            logic clr_hit;
            assign set_hit       = accept && (rd == REG_AW'(gi));
            assign clr_hit       = wb_en && (wb_addr == REG_AW'(gi));
            assign pending_d[gi] = set_hit || (pending_q[gi] && !clr_hit);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register and scoreboard update
    // ------------------------------------------------------------------
    logic [2:0]        out_op_q;
    logic [DATA_W-1:0] out_a_q;
    logic [DATA_W-1:0] out_b_q;
    logic [REG_AW-1:0] out_rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_rd_q    <= '0;
            pending_q   <= '0;
        end else begin
            pending_q <= pending_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_op_q    <= dec.op;
                out_a_q     <= opnd_a;
                out_b_q     <= opnd_b;
                out_rd_q    <= rd;
            end else if (out_ready) begin
                // Consumed with nothing new behind it: drop valid, keep data.
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_op    = out_op_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_rd    = out_rd_q;
    assign busy      = |pending_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;
    import alu_pkg::*;

`ifdef OPERAND_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_op;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [2:0]  out_rd;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        busy;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_rd    (out_rd),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .busy      (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: architectural registers, set of pending destinations,
    // and the operation currently held for the ALU.
    logic [15:0] m_reg [8];
    bit          m_pend [8];
    bit          m_ov;
    logic [2:0]  m_op;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic [2:0]  m_rd;
    bit          rdy_seen;

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] ra, input logic [2:0] rb,
                                       input logic ui, input logic [2:0] imm);
        return {op, rd, ra, rb, ui, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) begin
            m_reg[i]  = 16'h0;
            m_pend[i] = 1'b0;
        end
        m_ov = 1'b0; m_op = 3'd0; m_a = 16'h0; m_b = 16'h0; m_rd = 3'd0;
    endtask

    // A source is blocked while its register awaits a result, unless (with the
    // bypass) that very result is being written back this cycle.
    function automatic bit m_blocked(input logic [2:0] r, input bit wbe, input logic [2:0] wba);
        if (r == 3'd0 || !m_pend[r]) return 1'b0;
        if (FWD && wbe && wba == r) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [15:0] m_value(input logic [2:0] r, input bit wbe,
                                            input logic [2:0] wba, input logic [15:0] wbd);
        if (r == 3'd0) return 16'h0;
        if (FWD && wbe && wba == r) return wbd;
        return m_reg[r];
    endfunction

    function automatic bit m_busy();
        bit b = 1'b0;
        for (int i = 0; i < 8; i++) b = b | m_pend[i];
        return b;
    endfunction

    // One clock cycle: drive at negedge, check in_ready before the edge,
    // advance the model at posedge, check registered outputs just after.
    task automatic cycle(input bit r, input bit iv, input logic [15:0] ins, input bit ordy,
                         input bit wbe, input logic [2:0] wba, input logic [15:0] wbd);
        logic [2:0]  op, rd, ra, rb, imm;
        logic        ui;
        bit          hz, exp_rdy, acc;
        logic [15:0] va, vb;
        @(negedge clk);
        rst = r; in_valid = iv; in_instr = ins; out_ready = ordy;
        wb_en = wbe; wb_addr = wba; wb_data = wbd;
        {op, rd, ra, rb, ui, imm} = ins;
        hz = iv && (m_blocked(ra, wbe, wba) || (!ui && m_blocked(rb, wbe, wba))
                    || (rd != 3'd0 && m_pend[rd]));
        exp_rdy = !r && !hz && (!m_ov || ordy);
        acc = iv && exp_rdy;
        va = m_value(ra, wbe, wba, wbd);
        vb = ui ? {13'h0, imm} : m_value(rb, wbe, wba, wbd);
        #1;
        rdy_seen = in_ready;
        check("in_ready", {31'h0, in_ready}, {31'h0, exp_rdy});
        @(posedge clk);
        if (r) begin
            m_reset();
        end else begin
            if (wbe && wba != 3'd0) begin
                m_reg[wba]  = wbd;
                m_pend[wba] = 1'b0;
            end
            if (acc) begin
                if (rd != 3'd0) m_pend[rd] = 1'b1;
                m_ov = 1'b1; m_op = op; m_a = va; m_b = vb; m_rd = rd;
            end else if (ordy) begin
                m_ov = 1'b0;
            end
        end
        #1;
        check("out_valid", {31'h0, out_valid}, {31'h0, m_ov});
        check("out_op", {29'h0, out_op}, {29'h0, m_op});
        check("out_a", {16'h0, out_a}, {16'h0, m_a});
        check("out_b", {16'h0, out_b}, {16'h0, m_b});
        check("out_rd", {29'h0, out_rd}, {29'h0, m_rd});
        check("busy", {31'h0, busy}, {31'h0, m_busy()});
        $display("cyc rst=%0d iv=%0d instr=%04h ordy=%0d wb=%0d:%0d:%04h -> rdy=%0d ov=%0d op=%0d a=%04h b=%04h rd=%0d busy=%0d",
                 r, iv, ins, ordy, wbe, wba, wbd, rdy_seen, out_valid, out_op, out_a, out_b, out_rd, busy);
    endtask

    typedef struct packed {
        bit          r;
        bit          iv;
        logic [15:0] ins;
        bit          ordy;
        bit          wbe;
        logic [2:0]  wba;
        logic [15:0] wbd;
        bit          e_rdy;
        bit          e_ov;
        logic [2:0]  e_op;
        logic [15:0] e_a;
        logic [15:0] e_b;
        logic [2:0]  e_rd;
        bit          e_busy;
    } vec_t;

    vec_t tab [10];

    initial begin
        logic [2:0]  ops [4];
        logic [15:0] ins_hold;
        int          stalls;

        m_reset();
        rst = 1'b1; in_valid = 1'b0; in_instr = 16'h0; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = 3'd0; wb_data = 16'h0;

        //         r  iv ins                              ordy wbe wba   wbd       rdy ov op        a         b         rd   busy
        tab[0] = '{1, 0, 16'h0,                            1,  0, 3'd0, 16'h0,    0,  0, 3'd0,     16'h0,    16'h0,    3'd0, 0};
        tab[1] = '{0, 0, 16'h0,                            1,  0, 3'd0, 16'h0,    1,  0, 3'd0,     16'h0,    16'h0,    3'd0, 0};
        tab[2] = '{0, 1, mk(ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 3'd5),
                                                           1,  0, 3'd0, 16'h0,    1,  1, ALU_ADD,  16'h0,    16'h0005, 3'd1, 1};
        tab[3] = '{0, 0, 16'h0,                            1,  1, 3'd1, 16'h1234, 1,  0, ALU_ADD,  16'h0,    16'h0005, 3'd1, 0};
        tab[4] = '{0, 0, 16'h0,                            1,  1, 3'd2, 16'h00FF, 1,  0, ALU_ADD,  16'h0,    16'h0005, 3'd1, 0};
        tab[5] = '{0, 1, mk(ALU_OR, 3'd4, 3'd1, 3'd2, 1'b0, 3'd0),
                                                           1,  0, 3'd0, 16'h0,    1,  1, ALU_OR,   16'h1234, 16'h00FF, 3'd4, 1};
        tab[6] = '{0, 0, 16'h0,                            1,  1, 3'd4, 16'h5555, 1,  0, ALU_OR,   16'h1234, 16'h00FF, 3'd4, 0};
        tab[7] = '{0, 0, 16'h0,                            1,  1, 3'd0, 16'hFFFF, 1,  0, ALU_OR,   16'h1234, 16'h00FF, 3'd4, 0};
        tab[8] = '{0, 1, mk(ALU_NAND, 3'd0, 3'd0, 3'd4, 1'b0, 3'd0),
                                                           1,  0, 3'd0, 16'h0,    1,  1, ALU_NAND, 16'h0,    16'h5555, 3'd0, 0};
        tab[9] = '{0, 0, 16'h0,                            1,  0, 3'd0, 16'h0,    1,  0, ALU_NAND, 16'h0,    16'h5555, 3'd0, 0};

        // Reset, T1, T2, r0 write-ignore and rd=r0 never pending
        for (int i = 0; i < 10; i++) begin
            cycle(tab[i].r, tab[i].iv, tab[i].ins, tab[i].ordy, tab[i].wbe, tab[i].wba, tab[i].wbd);
            check($sformatf("tab%0d_ready", i), {31'h0, rdy_seen}, {31'h0, tab[i].e_rdy});
            check($sformatf("tab%0d_valid", i), {31'h0, out_valid}, {31'h0, tab[i].e_ov});
            check($sformatf("tab%0d_op", i), {29'h0, out_op}, {29'h0, tab[i].e_op});
            check($sformatf("tab%0d_a", i), {16'h0, out_a}, {16'h0, tab[i].e_a});
            check($sformatf("tab%0d_b", i), {16'h0, out_b}, {16'h0, tab[i].e_b});
            check($sformatf("tab%0d_rd", i), {29'h0, out_rd}, {29'h0, tab[i].e_rd});
            check($sformatf("tab%0d_busy", i), {31'h0, busy}, {31'h0, tab[i].e_busy});
        end

        // T3/T4 on ra: RAW on r3 stalls until writeback releases it
        cycle(0, 1, mk(ALU_SUB, 3'd3, 3'd1, 3'd1, 1'b0, 3'd0), 1, 0, 3'd0, 16'h0);
        check("t3_issue_ready", {31'h0, rdy_seen}, 32'd1);
        ins_hold = mk(ALU_ADD, 3'd5, 3'd3, 3'd0, 1'b1, 3'd1);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 1, ins_hold, 1, 0, 3'd0, 16'h0);
            check("t3_stall_ready", {31'h0, rdy_seen}, 32'd0);
        end
        cycle(0, 1, ins_hold, 1, 1, 3'd3, 16'hBEEF);
        check("t4a_wb_cycle_ready", {31'h0, rdy_seen}, {31'h0, FWD});
        stalls = 0;
        while (!rdy_seen && stalls < 3) begin
            cycle(0, 1, ins_hold, 1, 0, 3'd0, 16'h0);
            stalls++;
        end
        check("t4a_extra_cycles", stalls, FWD ? 32'd0 : 32'd1);
        check("t3_release_valid", {31'h0, out_valid}, 32'd1);
        check("t3_release_a", {16'h0, out_a}, 32'h0000BEEF);
        cycle(0, 0, 16'h0, 1, 1, 3'd5, 16'h0505);

        // T4 on rb: RAW on r6 with the writeback in the same cycle
        cycle(0, 1, mk(ALU_ADD, 3'd6, 3'd0, 3'd0, 1'b1, 3'd7), 1, 0, 3'd0, 16'h0);
        ins_hold = mk(ALU_OR, 3'd7, 3'd0, 3'd6, 1'b0, 3'd0);
        cycle(0, 1, ins_hold, 1, 1, 3'd6, 16'h0A0A);
        check("t4b_wb_cycle_ready", {31'h0, rdy_seen}, {31'h0, FWD});
        stalls = 0;
        while (!rdy_seen && stalls < 3) begin
            cycle(0, 1, ins_hold, 1, 0, 3'd0, 16'h0);
            stalls++;
        end
        check("t4b_extra_cycles", stalls, FWD ? 32'd0 : 32'd1);
        check("t4b_b", {16'h0, out_b}, 32'h00000A0A);
        cycle(0, 0, 16'h0, 1, 1, 3'd7, 16'h7777);

        // T5: downstream backpressure, then back-to-back issue
        cycle(0, 1, mk(ALU_ADD, 3'd0, 3'd1, 3'd0, 1'b1, 3'd2), 0, 0, 3'd0, 16'h0);
        check("t5_first_ready", {31'h0, rdy_seen}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, mk(ALU_SHL, 3'd0, 3'd2, 3'd0, 1'b1, 3'd3), 0, 0, 3'd0, 16'h0);
            check("t5_hold_ready", {31'h0, rdy_seen}, 32'd0);
            check("t5_frozen_a", {16'h0, out_a}, 32'h00001234);
            check("t5_frozen_b", {16'h0, out_b}, 32'h00000002);
        end
        ops[0] = ALU_SHL; ops[1] = ALU_SHR; ops[2] = ALU_SAR; ops[3] = ALU_SHADD;
        for (int k = 0; k < 4; k++) begin
            cycle(0, 1, mk(ops[k], 3'd0, 3'd2, 3'd0, 1'b1, 3'(k + 3)), 1, 0, 3'd0, 16'h0);
            check("t5_b2b_ready", {31'h0, rdy_seen}, 32'd1);
            check("t5_b2b_op", {29'h0, out_op}, {29'h0, ops[k]});
            check("t5_b2b_b", {16'h0, out_b}, 32'(k + 3));
            check("t5_b2b_a", {16'h0, out_a}, 32'h000000FF);
        end
        cycle(0, 0, 16'h0, 1, 0, 3'd0, 16'h0);

        // T6: reset with an operation in flight and a pending tag
        cycle(0, 1, mk(ALU_ADD, 3'd2, 3'd1, 3'd1, 1'b0, 3'd0), 1, 0, 3'd0, 16'h0);
        check("t6_pre_busy", {31'h0, busy}, 32'd1);
        cycle(1, 0, 16'h0, 1, 0, 3'd0, 16'h0);
        check("t6_valid", {31'h0, out_valid}, 32'd0);
        check("t6_busy", {31'h0, busy}, 32'd0);
        for (int i = 1; i < 8; i++) begin
            cycle(0, 1, mk(ALU_OR, 3'd0, 3'(i), 3'(i), 1'b0, 3'd0), 1, 0, 3'd0, 16'h0);
            check($sformatf("t6_r%0d_a", i), {16'h0, out_a}, 32'd0);
            check($sformatf("t6_r%0d_b", i), {16'h0, out_b}, 32'd0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 255) == 0),
                  ($urandom_range(0, 9) < 7),
                  16'($urandom),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 1) == 1),
                  3'($urandom_range(0, 7)),
                  16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
